inv_sub_byte_iter: RTL and testbench

INV_SUB_BYTE_ITER -- requirements
Module: inv_sub_byte_iter

---
 rtl/inv_sub_byte_iter.sv | 82 ++++++++
 tb/tb_inv_sub_byte_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_byte_iter.sv
// inv_sub_byte_iter: iterative AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per cycle
// Ports: clk; rst (sync, active-low); dataIn/inValid/inReady accept a state in IDLE;
// dataOut/outValid/outReady present the result in DONE; busy is high outside IDLE.
module inv_sub_byte_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] dataIn,
    input  logic         inValid,
    output logic         inReady,
    output logic [0:127] dataOut,
    output logic         outValid,
    input  logic         outReady,
    output logic         busy
);
    localparam int CHUNKS = 16 / BYTES_PER_CYCLE;
    localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    // Row-major FIPS-197 inverse S-box; entry b sits at bits [2047-8b -: 8]
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [0:127]  work, work_sub;
    logic          last;
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction
    assign last    = cnt == CW'(CHUNKS - 1);
    assign dataOut = work;
    // Working register with the current chunk substituted; one lookup per byte lane
    always_comb begin
        work_sub = work;
        for (int j = 0; j < BYTES_PER_CYCLE; j++)
            work_sub[8 * (int'(cnt) * BYTES_PER_CYCLE + j) +: 8] =
                inv_sbox(work[8 * (int'(cnt) * BYTES_PER_CYCLE + j) +: 8]);
    end
    always_comb begin
        state_nxt = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                inReady   = 1'b1;
                busy      = 1'b0;
                state_nxt = inValid ? BUSY : IDLE;
            end
            BUSY: state_nxt = last ? DONE : BUSY;
            DONE: begin
                outValid  = 1'b1;
                state_nxt = outReady ? IDLE : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && inValid) begin
                work <= dataIn;
                cnt  <= '0;
            end else if (state == BUSY) begin
                work <= work_sub;
                cnt  <= last ? cnt : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inv_sub_byte_iter.sv
// tb_inv_sub_byte_iter: scoreboard bench for inv_sub_byte_iter with directed FIPS-197 vectors
module tb_inv_sub_byte_iter;
    localparam logic [0:127] VA  = 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2;
    localparam logic [0:127] EA  = 128'h001F0E543C4E08596E221B0B4774311A;
    localparam logic [0:127] VB  = 128'h6AA0303D594E9CF4CB48989BBD129E8B;
    localparam logic [0:127] EB  = 128'h5847088B15B61CBA59D4E2E8CD39DFCE;
    localparam logic [0:127] Z   = 128'h0;
    localparam logic [0:127] E52 = {16{8'h52}};
    localparam logic [0:127] V63 = {16{8'h63}};

    logic clk = 0, rst = 0;
    logic [0:127] data_in, data_out;
    logic in_valid, in_ready, out_valid, out_ready, busy;
    logic sw_valid, one = 1'b1;
    logic [0:127] sw_data = VA;
    logic [0:127] d1_data, d16_data;
    logic d1_ready, d1_valid, d1_busy, d16_ready, d16_valid, d16_busy;

    int vectors = 0, errs = 0, cyc = 0;
    logic [0:127] q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    inv_sub_byte_iter #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .dataIn(data_in), .inValid(in_valid), .inReady(in_ready),
        .dataOut(data_out), .outValid(out_valid), .outReady(out_ready), .busy(busy));
    inv_sub_byte_iter #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .dataIn(sw_data), .inValid(sw_valid), .inReady(d1_ready),
        .dataOut(d1_data), .outValid(d1_valid), .outReady(one), .busy(d1_busy));
    inv_sub_byte_iter #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .dataIn(sw_data), .inValid(sw_valid), .inReady(d16_ready),
        .dataOut(d16_data), .outValid(d16_valid), .outReady(one), .busy(d16_busy));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one transaction, push its expected result, return cycles from accept to outValid
    task automatic send(input logic [0:127] d, input logic [0:127] e, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        chk("accept_ready", {127'b0, in_ready}, 1);
        in_valid = 1;
        data_in  = d;
        q.push_back(e);
        tick;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick;
            lat++;
        end
    endtask

    // Monitor: every handshake must match the oldest expected result
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_output: got %h expected no output", data_out);
            end else begin
                logic [0:127] e;
                e = q.pop_front();
                chk("result", data_out, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int lat, lat1, lat16, n;
        int acc[$];
        logic [0:127] cap1, cap16;
        in_valid = 0; out_ready = 1; sw_valid = 0; data_in = '0;
        rst = 0;
        repeat (2) tick;
        @(negedge clk);
        chk("rst_out_valid", {127'b0, out_valid}, 0);
        chk("rst_busy", {127'b0, busy}, 0);
        chk("rst_in_ready", {127'b0, in_ready}, 1);
        chk("rst_data_out", data_out, Z);
        tick;
        rst = 1;
        tick;

        send(VA, EA, lat);  chk("lat_A", lat, 4);
        tick;
        send(VB, EB, lat);  chk("lat_B", lat, 4);
        tick;
        send(Z, E52, lat);  chk("lat_00", lat, 4);
        tick;
        send(V63, Z, lat);  chk("lat_63", lat, 4);
        tick;

        // Backpressure with a competing request that must be ignored
        out_ready = 0;
        send(VB, EB, lat);  chk("lat_bp", lat, 4);
        in_valid = 1;
        data_in  = VA;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", {127'b0, out_valid}, 1);
            chk("bp_data", data_out, EB);
            chk("bp_in_ready", {127'b0, in_ready}, 0);
            tick;
        end
        out_ready = 1;
        tick;
        chk("release_in_ready", {127'b0, in_ready}, 1);
        chk("release_busy", {127'b0, busy}, 0);
        chk("release_out_valid", {127'b0, out_valid}, 0);
        in_valid = 0;
        tick;

        // Reset two cycles into an operation aborts it silently
        in_valid = 1;
        data_in  = VA;
        tick;
        in_valid = 0;
        tick;
        tick;
        rst = 0;
        tick;
        rst = 1;
        chk("abort_busy", {127'b0, busy}, 0);
        chk("abort_out_valid", {127'b0, out_valid}, 0);
        chk("abort_data_out", data_out, Z);
        repeat (8) begin
            tick;
            chk("abort_no_valid", {127'b0, out_valid}, 0);
        end
        send(VB, EB, lat);  chk("lat_after_abort", lat, 4);
        tick;

        // Back-to-back with inValid and outReady held high
        in_valid = 1;
        data_in  = VA;
        for (int c = 0; c < 100 && acc.size() < 4; c++) begin
            if (in_ready) begin
                q.push_back(acc.size() % 2 ? EB : EA);
                acc.push_back(cyc);
                tick;
                data_in = acc.size() % 2 ? VB : VA;
            end else tick;
        end
        in_valid = 0;
        chk("b2b_count", acc.size(), 4);
        for (int i = 1; i < acc.size(); i++) chk("b2b_period", acc[i] - acc[i-1], 6);

        // Parameter sweep: 1 and 16 bytes per cycle
        sw_valid = 1;
        tick;
        sw_valid = 0;
        lat1 = -1; lat16 = -1; cap1 = '0; cap16 = '0;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (d1_valid && lat1 < 0) begin lat1 = c; cap1 = d1_data; end
            if (d16_valid && lat16 < 0) begin lat16 = c; cap16 = d16_data; end
        end
        chk("sweep_lat_1", lat1, 16);
        chk("sweep_lat_16", lat16, 1);
        chk("sweep_data_1", cap1, EA);
        chk("sweep_data_16", cap16, EA);

        n = 0;
        while (q.size() > 0 && n < 100) begin
            tick;
            n++;
        end
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
